// File: rtl/risk_cache_upstream_param_pkg.sv
// Shared types for the pre-trade risk record cache.
// Opcodes, controller states and the default record layout.
package risk_cache_pkg;

  localparam int VAL_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_ORDER   = 2'd1,
    OP_SET_MAX = 2'd2,
    OP_CLEAR   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE,
    RESPOND
  } state_e;

  typedef struct packed {
    logic [VAL_W_DEF-1:0] max;
    logic [VAL_W_DEF-1:0] acc;
  } risk_rec_t;

endpackage

// File: rtl/risk_cache_upstream_param_if.sv
// Request, response and backing-memory bundle of the risk cache.
// slave = the cache, master = order path plus memory controller.
interface risk_cache_upstream_param_if #(
  parameter int CLIENT_W = 16,
  parameter int VAL_W    = 16
);

  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [CLIENT_W-1:0]   req_client;
  logic [VAL_W-1:0]      req_value;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_accept;
  logic [VAL_W-1:0]      rsp_max;
  logic [VAL_W-1:0]      rsp_acc;

  logic                  mem_req_valid;
  logic                  mem_req_rw;
  logic [CLIENT_W-1:0]   mem_req_client;
  logic [2*VAL_W-1:0]    mem_req_data;
  logic                  mem_ready;
  logic [2*VAL_W-1:0]    mem_rsp_data;

  modport slave (
    input  req_valid, req_op, req_client, req_value,
    input  rsp_ready, mem_ready, mem_rsp_data,
    output req_ready, rsp_valid, rsp_accept,
    output rsp_max, rsp_acc,
    output mem_req_valid, mem_req_rw,
    output mem_req_client, mem_req_data
  );

  modport master (
    output req_valid, req_op, req_client, req_value,
    output rsp_ready, mem_ready, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_accept,
    input  rsp_max, rsp_acc,
    input  mem_req_valid, mem_req_rw,
    input  mem_req_client, mem_req_data
  );

endinterface

// File: rtl/risk_cache_upstream_param_store.sv
// Direct-mapped line store: tag/valid/dirty plus record data.
// Async read; only valid and dirty bits are cleared by reset.
module risk_cache_store #(
  parameter int SETS   = 512,
  parameter int IDX_W  = $clog2(SETS),
  parameter int TAG_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              upd_en,
  input  logic [DATA_W-1:0] upd_data,
  input  logic              upd_dirty,
  input  logic              clr_dirty
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  // line state bits; a fill always lands clean
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (upd_en && upd_dirty)
        dirty_q[idx] <= 1'b1;
      if (clr_dirty)
        dirty_q[idx] <= 1'b0;
    end
  end

  // tag and record payload, no reset needed
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (upd_en) begin
      data_q[idx] <= upd_data;
    end
  end

endmodule

// File: rtl/risk_cache_upstream_param.sv
// Write-back risk record cache with in-line pre-trade check.
// One request in flight: lookup, optional write-back, fill, respond.
module risk_cache_upstream_param
  import risk_cache_pkg::*;
#(
  parameter int CLIENT_W = 16,
  parameter int SETS     = 512,
  parameter int VAL_W    = VAL_W_DEF
) (
  input logic clk,
  input logic rst,
  risk_cache_upstream_param_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = CLIENT_W - IDX_W;
  localparam int DAT_W = 2 * VAL_W;

  typedef struct packed {
    logic [VAL_W-1:0] max;
    logic [VAL_W-1:0] acc;
  } rec_t;

  state_e              state;
  op_e                 op_q;
  logic [CLIENT_W-1:0] client_q;
  logic [VAL_W-1:0]    value_q;

  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_accept_q;
  logic [VAL_W-1:0]    rsp_max_q;
  logic [VAL_W-1:0]    rsp_acc_q;
  logic                mem_valid_q;
  logic                mem_rw_q;
  logic [CLIENT_W-1:0] mem_client_q;
  logic [DAT_W-1:0]    mem_data_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [DAT_W-1:0]    rd_data;
  logic                hit;

  rec_t                cur;
  rec_t                nxt;
  logic [VAL_W:0]      sum;
  logic                accept;
  logic                mark;

  logic                fill_en;
  logic                upd_en;
  logic                clr_dirty;

  assign idx = client_q[IDX_W-1:0];
  assign tag = client_q[CLIENT_W-1:IDX_W];
  assign hit = rd_valid && (rd_tag == tag);
  assign cur = rec_t'(rd_data);

  assign upd_en    = (state == COMPARE) && hit;
  assign fill_en   = (state == ALLOCATE) && bus.mem_ready;
  assign clr_dirty = (state == WRITE_BACK) && bus.mem_ready;

  risk_cache_store #(
    .SETS   (SETS),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DAT_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_data (bus.mem_rsp_data),
    .upd_en    (upd_en),
    .upd_data  (nxt),
    .upd_dirty (mark),
    .clr_dirty (clr_dirty)
  );

  // risk decision on the looked-up record; sum is one bit wider
  always_comb begin
    nxt    = cur;
    accept = 1'b1;
    mark   = 1'b0;
    sum    = {1'b0, cur.acc} + {1'b0, value_q};
    unique case (1'b1)
      (op_q == OP_READ): begin
      end
      (op_q == OP_ORDER): begin
        if (value_q == '0) begin
          accept = 1'b1;
        end else if (sum <= {1'b0, cur.max}) begin
          nxt.acc = sum[VAL_W-1:0];
          mark    = 1'b1;
        end else begin
          accept = 1'b0;
        end
      end
      (op_q == OP_SET_MAX): begin
        nxt.max = value_q;
        accept  = (cur.acc <= value_q);
        mark    = 1'b1;
      end
      (op_q == OP_CLEAR): begin
        nxt.acc = '0;
        mark    = 1'b1;
      end
    endcase
  end

  // controller with registered handshake and memory outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      op_q         <= OP_READ;
      client_q     <= '0;
      value_q      <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_accept_q <= 1'b0;
      rsp_max_q    <= '0;
      rsp_acc_q    <= '0;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_client_q <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            op_q        <= op_e'(bus.req_op);
            client_q    <= bus.req_client;
            value_q     <= bus.req_value;
            req_ready_q <= 1'b0;
            state       <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            rsp_valid_q  <= 1'b1;
            rsp_accept_q <= accept;
            rsp_max_q    <= nxt.max;
            rsp_acc_q    <= nxt.acc;
            state        <= RESPOND;
          end else if (rd_valid && rd_dirty) begin
            mem_valid_q  <= 1'b1;
            mem_rw_q     <= 1'b1;
            mem_client_q <= {rd_tag, idx};
            mem_data_q   <= rd_data;
            state        <= WRITE_BACK;
          end else begin
            mem_valid_q  <= 1'b1;
            mem_rw_q     <= 1'b0;
            mem_client_q <= client_q;
            mem_data_q   <= '0;
            state        <= ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (bus.mem_ready) begin
            mem_rw_q     <= 1'b0;
            mem_client_q <= client_q;
            mem_data_q   <= '0;
            state        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            state       <= COMPARE;
          end
        end
        RESPOND: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_accept     = rsp_accept_q;
  assign bus.rsp_max        = rsp_max_q;
  assign bus.rsp_acc        = rsp_acc_q;
  assign bus.mem_req_valid  = mem_valid_q;
  assign bus.mem_req_rw     = mem_rw_q;
  assign bus.mem_req_client = mem_client_q;
  assign bus.mem_req_data   = mem_data_q;

endmodule

// File: tb/tb_risk_cache_upstream_param.sv
// Bench for the risk record cache: directed cases then random ops
// against a per-client record model and an index/tag residency model.
module tb_risk_cache_upstream_param;
  import risk_cache_pkg::*;

  localparam int NS = 512;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  risk_cache_upstream_param_if #(.CLIENT_W(16), .VAL_W(16)) bus ();

  risk_cache_upstream_param #(
    .CLIENT_W (16),
    .SETS     (NS),
    .VAL_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // golden records and backing memory, keyed by client id
  logic [31:0] gold      [logic [15:0]];
  logic [31:0] mem_store [logic [15:0]];

  // which client the model expects resident at each index
  bit          cv [NS];
  bit          cd [NS];
  logic [6:0]  ct [NS];

  bit          mem_en;
  int          mem_lat_max;
  logic [15:0] wb_cl_q [$];
  logic [31:0] wb_d_q  [$];
  logic [15:0] fill_q  [$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_gold(input logic [15:0] c);
    return gold.exists(c) ? gold[c] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [15:0] c);
    return mem_store.exists(c) ? mem_store[c] : 32'h0;
  endfunction

  // record semantics written from the op definitions
  function automatic void ref_op(input logic [1:0] op,
                                 input logic [31:0] cur,
                                 input logic [15:0] v,
                                 output logic [31:0] nr,
                                 output logic acc,
                                 output bit mark);
    int mx;
    int ac;
    mx   = int'(cur[31:16]);
    ac   = int'(cur[15:0]);
    nr   = cur;
    acc  = 1'b1;
    mark = 1'b0;
    case (op)
      2'd1: begin
        if (v != 16'h0) begin
          if (ac + int'(v) <= mx) begin
            nr[15:0] = 16'(ac + int'(v));
            mark     = 1'b1;
          end else begin
            acc = 1'b0;
          end
        end
      end
      2'd2: begin
        nr[31:16] = v;
        acc       = (ac <= int'(v));
        mark      = 1'b1;
      end
      2'd3: begin
        nr[15:0] = 16'h0;
        mark     = 1'b1;
      end
      default: ;
    endcase
  endfunction

  // backing memory: random latency, stable-request check, one-cycle ready
  initial begin : mem_model
    bit          pend;
    int          cnt;
    int          lat;
    logic        rw0;
    logic [15:0] cl0;
    logic [31:0] d0;
    pend = 0;
    cnt  = 0;
    lat  = 0;
    rw0  = 1'b0;
    cl0  = '0;
    d0   = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (!mem_en || !rst) begin
        pend = 0;
      end else if (bus.mem_req_valid) begin
        if (!pend) begin
          pend = 1;
          cnt  = 0;
          lat  = $urandom_range(0, mem_lat_max);
          rw0  = bus.mem_req_rw;
          cl0  = bus.mem_req_client;
          d0   = bus.mem_req_data;
        end else begin
          check("mem_stable_rw", bus.mem_req_rw, rw0);
          check("mem_stable_client", bus.mem_req_client, cl0);
          if (rw0)
            check("mem_stable_data", bus.mem_req_data, d0);
        end
        if (cnt >= lat) begin
          if (rw0) begin
            mem_store[cl0] = d0;
            wb_cl_q.push_back(cl0);
            wb_d_q.push_back(d0);
          end else begin
            bus.mem_rsp_data = rd_mem(cl0);
            fill_q.push_back(cl0);
          end
          bus.mem_ready = 1'b1;
          pend = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // one request end to end; hold = cycles rsp_ready is kept low
  task automatic do_req(input logic [1:0] op, input logic [15:0] cl,
                        input logic [15:0] val, input int hold,
                        output logic a_o, output logic [15:0] mx_o,
                        output logic [15:0] ac_o);
    logic [8:0]  ix;
    logic [6:0]  tg;
    bit          hit;
    bit          ewb;
    logic [15:0] wbc;
    logic [31:0] wbd;
    logic [31:0] cur;
    logic [31:0] nrec;
    logic        eacc;
    bit          mark;
    int          n;
    logic [32:0] snap;
    ix   = cl[8:0];
    tg   = cl[15:9];
    hit  = cv[ix] && (ct[ix] == tg);
    ewb  = !hit && cv[ix] && cd[ix];
    wbc  = {ct[ix], ix};
    wbd  = rd_gold(wbc);
    cur  = rd_gold(cl);
    ref_op(op, cur, val, nrec, eacc, mark);
    wb_cl_q.delete();
    wb_d_q.delete();
    fill_q.delete();
    a_o  = 1'b0;
    mx_o = '0;
    ac_o = '0;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 0, 1);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_client = cl;
    bus.req_value  = val;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.rsp_valid) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    // a hit raises rsp_valid on the edge after the handshake edge
    if (hit)
      check("hit_lat", n, 1);
    check("rsp_accept", bus.rsp_accept, eacc);
    check("rsp_max", bus.rsp_max, nrec[31:16]);
    check("rsp_acc", bus.rsp_acc, nrec[15:0]);
    check("req_ready_busy", bus.req_ready, 0);
    snap = {bus.rsp_accept, bus.rsp_max, bus.rsp_acc};
    a_o  = bus.rsp_accept;
    mx_o = bus.rsp_max;
    ac_o = bus.rsp_acc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_op     = 2'd3;
      bus.req_client = cl ^ 16'h0001;
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_stable",
            {bus.rsp_accept, bus.rsp_max, bus.rsp_acc}, snap);
      check("hold_req_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_drop", bus.rsp_valid, 0);
    check("idle_ready", bus.req_ready, 1);
    check("wb_count", wb_cl_q.size(), ewb ? 1 : 0);
    if (ewb && wb_cl_q.size() > 0) begin
      check("wb_client", wb_cl_q[0], wbc);
      check("wb_data", wb_d_q[0], wbd);
    end
    check("fill_count", fill_q.size(), hit ? 0 : 1);
    if (!hit && fill_q.size() > 0)
      check("fill_client", fill_q[0], cl);
    gold[cl] = nrec;
    if (!hit) begin
      cv[ix] = 1'b1;
      ct[ix] = tg;
      cd[ix] = mark;
    end else begin
      cd[ix] = cd[ix] | mark;
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        a;
    logic [15:0] mx;
    logic [15:0] ac;
    int          n;
    logic [15:0] pool [12];
    logic [1:0]  op;
    logic [15:0] cl;
    logic [15:0] v;
    rst           = 1'b1;
    mem_en        = 1'b0;
    mem_lat_max   = 1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_client = '0;
    bus.req_value = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      cv[i] = 1'b0;
      cd[i] = 1'b0;
      ct[i] = '0;
    end
    #1 rst = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_accept", bus.rsp_accept, 0);
    check("rst_rsp_rec", {bus.rsp_max, bus.rsp_acc}, 0);
    check("rst_mem_valid", bus.mem_req_valid, 0);
    check("rst_mem_rw", bus.mem_req_rw, 0);
    check("rst_mem_out", {bus.mem_req_client, bus.mem_req_data}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", bus.req_ready, 1);

    // reset while a fill is outstanding
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'd0;
    bus.req_client = 16'h0005;
    bus.req_value  = '0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.mem_req_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_fill_req", bus.mem_req_valid, 1);
    check("t1_fill_rw", bus.mem_req_rw, 0);
    check("t1_fill_client", bus.mem_req_client, 16'h0005);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t1_rst_mem_valid", bus.mem_req_valid, 0);
    check("t1_rst_req_ready", bus.req_ready, 0);
    @(negedge clk);
    rst    = 1'b1;
    mem_en = 1'b1;
    @(posedge clk);
    #1;
    check("t1_ready_after_rst", bus.req_ready, 1);
    do_req(2'd0, 16'h0005, 16'h0, 0, a, mx, ac);

    // limit set then orders around the limit
    do_req(2'd0, 16'h0205, 16'h0, 0, a, mx, ac);
    do_req(2'd2, 16'h0005, 16'd100, 0, a, mx, ac);
    check("t2_set", {a, mx, ac}, {1'b1, 16'd100, 16'd0});
    do_req(2'd1, 16'h0005, 16'd60, 0, a, mx, ac);
    check("t2_ord60", {a, ac}, {1'b1, 16'd60});
    do_req(2'd1, 16'h0005, 16'd41, 0, a, mx, ac);
    check("t2_ord41", {a, ac}, {1'b0, 16'd60});

    // equality boundary and lowering the limit below acc
    do_req(2'd1, 16'h0005, 16'd40, 0, a, mx, ac);
    check("t3_ord40", {a, ac}, {1'b1, 16'd100});
    do_req(2'd2, 16'h0005, 16'd50, 0, a, mx, ac);
    check("t3_set50", {a, mx, ac}, {1'b0, 16'd50, 16'd100});

    // aliasing eviction writes the dirty record back
    do_req(2'd2, 16'h0005, 16'd100, 0, a, mx, ac);
    do_req(2'd3, 16'h0005, 16'd0, 0, a, mx, ac);
    do_req(2'd1, 16'h0005, 16'd60, 0, a, mx, ac);
    do_req(2'd0, 16'h0205, 16'd0, 0, a, mx, ac);
    check("t4_wb_n", wb_cl_q.size(), 1);
    if (wb_cl_q.size() > 0) begin
      check("t4_wb_client", wb_cl_q[0], 16'h0005);
      check("t4_wb_data", wb_d_q[0], 32'h0064_003C);
    end
    do_req(2'd0, 16'h0005, 16'd0, 0, a, mx, ac);
    check("t4_refetch", {mx, ac}, {16'd100, 16'd60});

    // top of the value range, no wrap on the sum
    do_req(2'd2, 16'h0005, 16'hFFFF, 0, a, mx, ac);
    do_req(2'd3, 16'h0005, 16'h0, 0, a, mx, ac);
    do_req(2'd1, 16'h0005, 16'hFFF0, 0, a, mx, ac);
    do_req(2'd1, 16'h0005, 16'h0020, 0, a, mx, ac);
    check("t5_nowrap", {a, ac}, {1'b0, 16'hFFF0});
    do_req(2'd1, 16'h0005, 16'h000F, 0, a, mx, ac);
    check("t5_fill_top", {a, ac}, {1'b1, 16'hFFFF});

    // response back-pressure with a competing request
    do_req(2'd0, 16'h0005, 16'h0, 5, a, mx, ac);
    check("t6_rec", {mx, ac}, {16'hFFFF, 16'hFFFF});

    // random traffic over aliasing clients with preloaded memory
    for (int i = 0; i < 12; i++)
      pool[i] = {7'(i % 4), 9'(i < 4 ? 5 : (i < 8 ? 3 : 7))};
    for (int i = 4; i < 12; i++) begin
      v = 16'($urandom_range(50, 300));
      mem_store[pool[i]] = {v, 16'($urandom_range(0, 60))};
      gold[pool[i]] = mem_store[pool[i]];
    end
    mem_lat_max = 3;
    repeat (200) begin
      op = 2'($urandom_range(0, 3));
      cl = pool[$urandom_range(0, 11)];
      if (op == 2'd1)
        v = ($urandom_range(0, 7) == 0) ? 16'h0 :
            16'($urandom_range(1, 60));
      else
        v = 16'($urandom_range(0, 400));
      do_req(op, cl, v, $urandom_range(0, 2), a, mx, ac);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
